// File: rtl/regfile_pkg.sv
// Shared constants for the CPU general-purpose register file.
// Provides default geometry, special-slot indices and reset values.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
  localparam int unsigned DEFAULT_NUM_REGS   = 13;

  // Debug names for the special-purpose slots
  localparam int unsigned CMP_INDEX = 9;
  localparam int unsigned SP_INDEX  = 10;
  localparam int unsigned SF_INDEX  = 11;
  localparam int unsigned PC_INDEX  = 12;

  localparam logic [DEFAULT_DATA_WIDTH-1:0] SP_RESET = 8'hFF;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] PC_RESET = 8'h00;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational register-file read port.
// Ports: read_id -> read_value; regs is the implemented storage (1..NUM_REGS-1);
// write_legal/write_id/write_value drive the write-first bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = DEFAULT_NUM_REGS
) (
  input  logic [ADDR_WIDTH-1:0]               read_id,
  input  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs,
  input  logic                                write_legal,
  input  logic [ADDR_WIDTH-1:0]               write_id,
  input  logic [DATA_WIDTH-1:0]               write_value,
  output logic [DATA_WIDTH-1:0]               read_value
);

  // Index 0 and unmapped indices fall through to zero; a legal write to the
  // same index wins over stored state.
  always_comb begin
    read_value = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (read_id == ADDR_WIDTH'(i)) read_value = regs[i];
    end
    if (write_legal && (read_id == write_id)) read_value = write_value;
  end

endmodule

// File: rtl/register_file_ctl.sv
// General-purpose register file with two bypassed read ports, one write port,
// and auto-updating SP/PC slots.
// Ports: clk, reset (async, active high); read1/read2 id->value (combinational);
// write_en/write_id/write_value; pc_inc, sp_push, sp_pop; pc_value, sp_value
// (registered); illegal_write (pulse the cycle after an ignored write).
module register_file_ctl
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = DEFAULT_NUM_REGS,
  parameter int unsigned SP_IDX     = SP_INDEX,
  parameter int unsigned PC_IDX     = PC_INDEX,
  parameter logic [DATA_WIDTH-1:0] SP_RST = SP_RESET,
  parameter logic [DATA_WIDTH-1:0] PC_RST = PC_RESET
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read1_id,
  output logic [DATA_WIDTH-1:0] read1_value,
  input  logic [ADDR_WIDTH-1:0] read2_id,
  output logic [DATA_WIDTH-1:0] read2_value,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_id,
  input  logic [DATA_WIDTH-1:0] write_value,
  input  logic                  pc_inc,
  input  logic                  sp_push,
  input  logic                  sp_pop,
  output logic [DATA_WIDTH-1:0] pc_value,
  output logic [DATA_WIDTH-1:0] sp_value,
  output logic                  illegal_write
);

  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs_d;
  logic write_legal_c;
  logic pc_written_c;
  logic sp_written_c;

  // Legal write: nonzero index inside the implemented range
  assign write_legal_c = write_en && (write_id != '0) && (32'(write_id) < NUM_REGS);
  assign pc_written_c  = write_legal_c && (write_id == ADDR_WIDTH'(PC_IDX));
  assign sp_written_c  = write_legal_c && (write_id == ADDR_WIDTH'(SP_IDX));

  // Next state: explicit write first, then PC/SP auto-updates when not written
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (write_legal_c && (write_id == ADDR_WIDTH'(i))) regs_d[i] = write_value;
    end
    if (!pc_written_c && pc_inc) regs_d[PC_IDX] = regs_q[PC_IDX] + DATA_WIDTH'(1);
    if (!sp_written_c) begin
      case ({sp_push, sp_pop})
        2'b10:   regs_d[SP_IDX] = regs_q[SP_IDX] - DATA_WIDTH'(1);
        2'b01:   regs_d[SP_IDX] = regs_q[SP_IDX] + DATA_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Storage and illegal-write flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (i == SP_IDX)      regs_q[i] <= SP_RST;
        else if (i == PC_IDX) regs_q[i] <= PC_RST;
        else                  regs_q[i] <= '0;
      end
      illegal_write <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      illegal_write <= write_en && !write_legal_c;
    end
  end

  assign pc_value = regs_q[PC_IDX];
  assign sp_value = regs_q[SP_IDX];

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_read1 (
    .read_id(read1_id), .regs(regs_q), .write_legal(write_legal_c),
    .write_id(write_id), .write_value(write_value), .read_value(read1_value)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)
  ) u_read2 (
    .read_id(read2_id), .regs(regs_q), .write_legal(write_legal_c),
    .write_id(write_id), .write_value(write_value), .read_value(read2_value)
  );

endmodule

// File: doc/register_file_ctl.md
Name: register_file_ctl

Overview:
- Clocked, parametrised general-purpose register file for the CPU datapath, between instruction decode and the ALU/memory stage.
- Two combinational read ports with write-to-read bypass and one synchronous write port with enable.
- Register 0 reads as zero; stack-pointer and program-counter slots have their own auto-update logic.
- Writes to register 0 or to an unmapped index are flagged.

Parameters:
- DATA_WIDTH, 8, bits per register
- ADDR_WIDTH, 4, register index width
- NUM_REGS, 13, implemented registers, indices 0..NUM_REGS-1; must be ≤ 2**ADDR_WIDTH
- SP_INDEX, 10, index of stack pointer
- PC_INDEX, 12, index of program counter
- SP_RESET, 8'hFF, stack pointer reset value
- PC_RESET, 8'h00, program counter reset value

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- read1_id  in  ADDR_WIDTH  read port 1 index
- read1_value  out  DATA_WIDTH  read port 1 data
- read2_id  in  ADDR_WIDTH  read port 2 index
- read2_value  out  DATA_WIDTH  read port 2 data
- write_en  in  1  write strobe
- write_id  in  ADDR_WIDTH  write index
- write_value  in  DATA_WIDTH  write data
- pc_inc  in  1  increment PC by 1 this cycle
- sp_push  in  1  decrement SP by 1 this cycle
- sp_pop  in  1  increment SP by 1 this cycle
- pc_value  out  DATA_WIDTH  current PC, registered
- sp_value  out  DATA_WIDTH  current SP, registered
- illegal_write  out  1  one-cycle pulse, cycle after an ignored write

Behaviour:
- Reset (async assert, released synchronously by the integrator):
  - all registers cleared to 0, except SP = SP_RESET and PC = PC_RESET
  - illegal_write = 0
  - reads still function combinationally during reset
- Write:
  - on rising clk with write_en=1 and 1 ≤ write_id < NUM_REGS: reg[write_id] <= write_value
  - write_id = 0 or write_id ≥ NUM_REGS: no state change; illegal_write = 1 next cycle
  - write_en = 0: illegal_write = 0 next cycle
- Read (combinational, zero latency):
  - read_id = 0 or ≥ NUM_REGS: returns 0
  - read_id == write_id with write_en=1 and a legal write: returns write_value (bypass, write-first)
  - otherwise returns reg[read_id]
  - both ports are independent; identical ids on both ports are allowed
- PC update per edge, priority highest first:
  1. explicit legal write to PC_INDEX
  2. pc_inc: PC <= PC+1, wrapping modulo 2**DATA_WIDTH (FF -> 00)
  3. hold
- SP update per edge, priority highest first:
  1. explicit legal write to SP_INDEX
  2. sp_push=1 and sp_pop=1 together: net hold
  3. sp_push: SP-1, wrapping 00 -> FF
  4. sp_pop: SP+1, wrapping FF -> 00
  5. hold
- Bypass does not reflect pc_inc/sp_push/sp_pop; reads of PC/SP return the pre-edge value unless an explicit write is in flight.
- pc_value and sp_value mirror register state directly (no bypass).
- Reset asserted mid-cycle overrides every pending write and update; the next edge after deassertion acts normally.

Decomposition:
- Shared package regfile_pkg: DATA_WIDTH and ADDR_WIDTH defaults, SP_INDEX, PC_INDEX, reset constants. Debug names for cmp/sp/sf/pc indices live as localparams there.
- One natural sub-module, regfile_read_port: index range check, zero-register handling and bypass mux. Instantiated twice.

Test Plan:
- Reset, then read all ids 0..15 -> 0 everywhere except id 10 = FF and id 12 = 00; illegal_write = 0.
- write_en=1, id 3, value A5; same cycle read1_id=3 -> read1_value=A5 (bypass); after the edge with write_en=0 -> A5 still held.
- write_en=1, id 0, value 55 -> reg0 still reads 00; illegal_write pulses 1 for exactly one cycle. Repeat with id 14 -> same result.
- PC at FE, pc_inc held 3 cycles -> pc_value FF, 00, 01. Same cycle as pc_inc, write id 12 value 40 -> PC=40.
- SP = FF: sp_push twice -> FE, FD; sp_push and sp_pop together -> FD; SP = 00 with sp_push -> FF.
- Write id 5 value 77, assert reset asynchronously before the edge -> reg5 = 00 and SP = FF; first edge after release writes normally.
